mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped transmit-only UART on the CPU data bus, directly downstream of the CPU's `dAddr`/`dataOut`/`DRAMwe` outputs. It decodes a 16-byte window, buffers written bytes in a small FIFO, and serialises them as 8N1 frames on `txd`. Its combinational read data is muxed into the CPU's `dataIn` by the top level. All other addresses pass through to DRAM with a gated write enable.

## Interface
- `BASE_ADDR`, 32'hFFFF_0000: window base; bits [3:0] must be 0.
- `CLKS_PER_BIT`, 16: clocks per serial bit; must be ≥2.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of 2, ≥2.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `dAddr` in 32: CPU data address.
- `dataOut` in 32: CPU store data.
- `DRAMwe` in 1: CPU store strobe.
- `sel` out 1: `dAddr[31:4] == BASE_ADDR[31:4]`; combinational.
- `dram_we` out 1: `DRAMwe & ~sel`; combinational.
- `rdata` out 32: register read data; combinational; 0 when `sel`=0.
- `txd` out 1: serial output, idle high.
- `irq` out 1: level interrupt; registered-state derived.

## Operation
- Register map, offset `dAddr[3:2]`:
  - 0 TXDATA: a write pushes `dataOut[7:0]`; reads return 0.
  - 1 STATUS: bit0 full, bit1 empty, bit2 busy (FSM≠IDLE), bit3 ovf (sticky), bits[15:8] FIFO count; writing 1 to bit3 clears ovf.
  - 2 CTRL: bit0 en (reset 1), bit1 irq_en (reset 0); read/write.
  - 3: reads 0; writes ignored.
- A write takes effect at the rising edge where `sel & DRAMwe`=1.
- Push to a full FIFO: byte dropped, ovf set. Fullness is the pre-edge count; a same-edge pop does not make room.
- Serialiser FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: if en and FIFO non-empty, pop the head into the shift register and go to START.
  - START: `txd`=0 for one bit time.
  - DATA: 8 bits, LSB first.
  - STOP: `txd`=1 for one bit time.
  - Bit timer counts 0..CLKS_PER_BIT-1; state/bit advance on terminal count.
- Clearing en mid-frame: the current frame completes; no further pops until en=1.
- `irq` = irq_en & empty & ~busy.
- Reset values: FIFO empty, ovf=0, en=1, irq_en=0, FSM IDLE, `txd`=1, `irq`=0.
- Reset mid-frame: `txd` returns high immediately; the frame and FIFO contents are lost.

## Timing
- Write to TXDATA at edge T with the FSM idle and en=1:
  - pop and IDLE→START at edge T+1;
  - `txd` low from T+1 through T+1+CLKS_PER_BIT.
- Frame length is 10·CLKS_PER_BIT clocks. STOP→IDLE costs one clock, so back-to-back frames start 10·CLKS_PER_BIT+1 clocks apart.
- STATUS/count reflect the post-edge state in the cycle after a push or pop.
- `rdata`, `sel` and `dram_we` have zero latency. Reads have no side effects.
- Push and pop on the same edge: count is unchanged (when not full).

## Structure
- Package `mmio_uart_pkg`: register offset constants, STATUS/CTRL bit indices, FSM state enum.
- Sub-module `uart_tx_fifo`:
  - synchronous FIFO, `FIFO_DEPTH`×8;
  - ports push/pop/din/dout/full/empty/count;
  - pointers wrap modulo depth, count is log2(DEPTH)+1 bits.
- Top module: address decode, registers, serialiser FSM.

## Test plan
- Reset, then read STATUS → 0x0000_0002 (empty); `txd`=1, `irq`=0; a store to 0x0000_0100 gives `dram_we`=1, `sel`=0.
- CLKS_PER_BIT=4: write 0xA5 to BASE+0 → `txd` shows 0,1,0,1,0,0,1,0,1,1, each held 4 clocks, starting one clock after the write. Total 40 clocks, then busy=0.
- Write 9 bytes in consecutive cycles with en=0 (DEPTH=8) → count=8, full=1, ovf=1. Writing 0x8 to STATUS clears ovf. Set en=1 → 8 frames, 41 clocks apart.
- Set CTRL=0x3 with the FIFO empty → `irq`=1. Write a byte → `irq`=0 until its stop bit completes, then 1.
- Assert `reset` low mid-DATA → `txd`=1 asynchronously, STATUS=0x2, CTRL=0x1 after release.
- Access offset 0xC and addresses outside the window → `rdata`=0 / `sel`=0. FIFO and registers unchanged.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register offsets,
// STATUS/CTRL bit positions and the serialiser state encoding.
package mmio_uart_pkg;

  localparam int unsigned BYTE_W = 8;

  // Register offsets, decoded from dAddr[3:2]
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;
  localparam logic [1:0] OFF_RSVD   = 2'd3;

  // STATUS bit positions
  localparam int unsigned ST_FULL    = 0;
  localparam int unsigned ST_EMPTY   = 1;
  localparam int unsigned ST_BUSY    = 2;
  localparam int unsigned ST_OVF     = 3;
  localparam int unsigned ST_CNT_LSB = 8;

  // CTRL bit positions
  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the UART serialiser. Pushes while full and
// pops while empty are ignored; pointers wrap modulo the (power-of-2) depth.
module uart_tx_fifo
  import mmio_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic [BYTE_W-1:0]           din,
  output logic [BYTE_W-1:0]           dout,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [BYTE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped transmit-only UART. Decodes a 16-byte window on the CPU data
// bus, gates DRAM writes for that window, buffers bytes in a FIFO and sends
// them as 8N1 frames on txd.
module mmio_uart_tx
  import mmio_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dAddr,
  input  logic [31:0] dataOut,
  input  logic        DRAMwe,
  output logic        sel,
  output logic        dram_we,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);

  logic [1:0]        offset;
  logic              wr_en;
  logic              push;
  logic              pop;
  logic [BYTE_W-1:0] fifo_dout;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;

  logic              ovf;
  logic              en;
  logic              irq_en;

  tx_state_t         state;
  logic [TW-1:0]     timer;
  logic              tc;
  logic [2:0]        bit_idx;
  logic [BYTE_W-1:0] shreg;
  logic              txd_q;
  logic              busy;

  logic              unused_bits;
  assign unused_bits = ^{dataOut[31:8], dAddr[1:0]};

  assign sel     = (dAddr[31:4] == BASE_ADDR[31:4]);
  assign dram_we = DRAMwe & ~sel;
  assign wr_en   = sel & DRAMwe;
  assign offset  = dAddr[3:2];

  assign push = wr_en && (offset == OFF_TXDATA);
  assign pop  = (state == S_IDLE) && en && !empty;
  assign busy = (state != S_IDLE);
  assign tc   = (timer == TW'(CLKS_PER_BIT - 1));
  assign txd  = txd_q;
  assign irq  = irq_en & empty & ~busy;

  uart_tx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (dataOut[BYTE_W-1:0]),
    .dout (fifo_dout),
    .full (full),
    .empty(empty),
    .count(count)
  );

  // Control/status registers; overflow is judged on the pre-edge full flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf    <= 1'b0;
      en     <= 1'b1;
      irq_en <= 1'b0;
    end else begin
      if (push && full)
        ovf <= 1'b1;
      else if (wr_en && offset == OFF_STATUS && dataOut[ST_OVF])
        ovf <= 1'b0;
      if (wr_en && offset == OFF_CTRL) begin
        en     <= dataOut[CTRL_EN];
        irq_en <= dataOut[CTRL_IRQ_EN];
      end
    end
  end

  // Serialiser: IDLE pops a byte, then START, 8 DATA bits LSB first, STOP
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      txd_q   <= 1'b1;
    end else begin
      if (state == S_IDLE) timer <= '0;
      else                 timer <= tc ? '0 : timer + 1'b1;
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg <= fifo_dout;
            txd_q <= 1'b0;
            state <= S_START;
          end
        end
        S_START: begin
          if (tc) begin
            txd_q   <= shreg[0];
            shreg   <= {1'b0, shreg[BYTE_W-1:1]};
            bit_idx <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (tc) begin
            if (bit_idx == 3'd7) begin
              txd_q <= 1'b1;
              state <= S_STOP;
            end else begin
              txd_q   <= shreg[0];
              shreg   <= {1'b0, shreg[BYTE_W-1:1]};
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        S_STOP: begin
          if (tc) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register read mux; zero outside the window and for TXDATA/reserved
  always_comb begin
    rdata = '0;
    if (sel) begin
      case (offset)
        OFF_STATUS: begin
          rdata[ST_FULL]              = full;
          rdata[ST_EMPTY]             = empty;
          rdata[ST_BUSY]              = busy;
          rdata[ST_OVF]               = ovf;
          rdata[ST_CNT_LSB +: BYTE_W] = BYTE_W'(count);
        end
        OFF_CTRL: begin
          rdata[CTRL_EN]     = en;
          rdata[CTRL_IRQ_EN] = irq_en;
        end
        default: rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam int unsigned CPB  = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dAddr = '0;
  logic [31:0] dataOut = '0;
  logic        DRAMwe = 1'b0;
  logic        sel, dram_we, txd, irq;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] sb[$];

  mmio_uart_tx #(
    .BASE_ADDR(BASE),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .dAddr(dAddr), .dataOut(dataOut),
    .DRAMwe(DRAMwe), .sel(sel), .dram_we(dram_we), .rdata(rdata),
    .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    dAddr  = a;
    DRAMwe = 1'b0;
    #1 d = rdata;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    dAddr   = a;
    dataOut = d;
    DRAMwe  = 1'b1;
    if (a == BASE) sb.push_back(d[7:0]);
    @(negedge clk);
    DRAMwe = 1'b0;
    dAddr  = '0;
  endtask

  // Frame monitor: decodes txd at mid-bit and checks against the scoreboard
  bit         mon_active = 0;
  int         mon_cnt = 0;
  logic [7:0] mon_sh = '0;
  bit         chk_gap = 0;
  int         prev_start = -1;

  always @(negedge clk) begin
    if (!reset) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (txd == 1'b0) begin
        mon_active = 1;
        mon_cnt = 0;
        if (chk_gap && prev_start >= 0) chk("frame_gap", cyc - prev_start, 41);
        prev_start = cyc;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt >= 6 && mon_cnt <= 34 && (mon_cnt - 6) % 4 == 0)
        mon_sh[(mon_cnt - 6) / 4] = txd;
      if (mon_cnt == 38) begin
        chk("stop_bit", {31'b0, txd}, 32'd1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected: got 0x%02h expected no frame", mon_sh);
        end else begin
          chk("frame_byte", {24'b0, mon_sh}, {24'b0, sb.pop_front()});
        end
      end
      if (mon_cnt == 39) mon_active = 0;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_sel;
    logic        exp_dwe;
  } vec_t;

  vec_t vecs[12];

  logic [31:0] d;
  logic [7:0]  a5_bits;
  logic [7:0]  b;
  bit          low_ok;

  initial begin
    vecs[0]  = '{BASE + 32'h4, 1'b0, 32'h0, 32'h2, 1'b1, 1'b0};
    vecs[1]  = '{BASE + 32'h8, 1'b0, 32'h0, 32'h1, 1'b1, 1'b0};
    vecs[2]  = '{BASE + 32'h0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[3]  = '{BASE + 32'hC, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[4]  = '{BASE + 32'hC, 1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0};
    vecs[5]  = '{32'h0000_0100, 1'b1, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1};
    vecs[6]  = '{32'h0000_0100, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[7]  = '{BASE + 32'h10, 1'b1, 32'h77, 32'h0, 1'b0, 1'b1};
    vecs[8]  = '{32'hFFFE_FFFC, 1'b1, 32'h3, 32'h0, 1'b0, 1'b1};
    vecs[9]  = '{BASE + 32'h4, 1'b1, 32'h8, 32'h2, 1'b1, 1'b0};
    vecs[10] = '{BASE + 32'hF, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[11] = '{BASE + 32'h6, 1'b0, 32'h0, 32'h2, 1'b1, 1'b0};

    // Reset
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_txd", {31'b0, txd}, 32'd1);
    chk("reset_irq", {31'b0, irq}, 32'd0);
    do_read(BASE + 32'h4, d);
    chk("reset_status", d, 32'h2);

    // Address decode / register table
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      dAddr   = vecs[i].addr;
      dataOut = vecs[i].wdata;
      DRAMwe  = vecs[i].we;
      #1;
      chk($sformatf("vec%0d_sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
      chk($sformatf("vec%0d_dram_we", i), {31'b0, dram_we}, {31'b0, vecs[i].exp_dwe});
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
    end
    @(negedge clk);
    DRAMwe = 1'b0;
    do_read(BASE + 32'h4, d);
    chk("table_status_unchanged", d, 32'h2);
    do_read(BASE + 32'h8, d);
    chk("table_ctrl_unchanged", d, 32'h1);

    // Bit-exact frame for 0xA5
    a5_bits = 8'hA5;
    do_write(BASE, 32'hA5);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i < 4)       chk($sformatf("a5_txd_%0d", i), {31'b0, txd}, 32'd0);
      else if (i < 36) chk($sformatf("a5_txd_%0d", i), {31'b0, txd}, {31'b0, a5_bits[(i - 4) / 4]});
      else             chk($sformatf("a5_txd_%0d", i), {31'b0, txd}, 32'd1);
    end
    do_read(BASE + 32'h4, d);
    chk("a5_done_status", d, 32'h2);

    // Overflow with en=0, then drain with frame spacing checks
    do_write(BASE + 32'h8, 32'h0);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      b = 8'($urandom);
      dAddr   = BASE;
      dataOut = {24'b0, b};
      DRAMwe  = 1'b1;
      if (k < 8) sb.push_back(b);
    end
    @(negedge clk);
    DRAMwe = 1'b0;
    repeat (3) @(negedge clk);
    do_read(BASE + 32'h4, d);
    chk("ovf_status", d, 32'h0000_0809);
    do_write(BASE + 32'h4, 32'h8);
    do_read(BASE + 32'h4, d);
    chk("ovf_cleared", d, 32'h0000_0801);
    chk_gap = 1;
    prev_start = -1;
    do_write(BASE + 32'h8, 32'h1);
    repeat (8 * 41 + 10) @(negedge clk);
    chk_gap = 0;
    chk("drain_sb_empty", sb.size(), 0);
    do_read(BASE + 32'h4, d);
    chk("drain_status", d, 32'h2);

    // Interrupt behaviour
    do_write(BASE + 32'h8, 32'h3);
    #1 chk("irq_set", {31'b0, irq}, 32'd1);
    do_write(BASE, 32'h3C);
    #1 chk("irq_cleared_on_push", {31'b0, irq}, 32'd0);
    low_ok = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (irq !== 1'b0) low_ok = 0;
    end
    chk("irq_low_during_frame", {31'b0, low_ok}, 32'd1);
    @(negedge clk);
    chk("irq_after_stop", {31'b0, irq}, 32'd1);

    // Asynchronous reset mid-DATA
    do_write(BASE, 32'h55);
    repeat (9) @(negedge clk);
    chk("pre_reset_txd_low", {31'b0, txd}, 32'd0);
    #2 reset = 1'b0;
    #1 chk("async_reset_txd", {31'b0, txd}, 32'd1);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    do_read(BASE + 32'h4, d);
    chk("post_reset_status", d, 32'h2);
    do_read(BASE + 32'h8, d);
    chk("post_reset_ctrl", d, 32'h1);
    repeat (50) @(negedge clk);
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
